// File: rtl/arm_pkg.sv
// arm_pkg: shared register-index constants and the MEM/WB pipeline bundle
package arm_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS = 15;
  localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;
  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic                 r_en;
    logic [31:0]          alu_res;
    logic [31:0]          data;
    logic [REG_IDX_W-1:0] dest;
  } wb_bundle;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register in-flight write counters with two hazard query ports
module wb_scoreboard import arm_pkg::*; #(
  parameter int NUM_REGS = 15,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic [REG_IDX_W-1:0] inc_idx_i,
  input  logic                 dec_i,
  input  logic [REG_IDX_W-1:0] dec_idx_i,
  input  logic                 wb_we_i,
  input  logic [REG_IDX_W-1:0] wb_idx_i,
  input  logic [REG_IDX_W-1:0] src1_i,
  input  logic [REG_IDX_W-1:0] src2_i,
  input  logic                 use2_i,
  output logic                 hazard1_o,
  output logic                 hazard2_o
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_v, dec_v;
  logic [CNT_W-1:0] c1, c2;
  always_comb begin
    c1 = '0;
    c2 = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_v[r] = inc_i && inc_idx_i == REG_IDX_W'(r);
      dec_v[r] = dec_i && dec_idx_i == REG_IDX_W'(r);
      cnt_d[r] = (inc_v[r] && !dec_v[r] && cnt_q[r] != MAX) ? cnt_q[r] + CNT_W'(1) :
                 (dec_v[r] && !inc_v[r] && cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
      if (src1_i == REG_IDX_W'(r)) c1 = cnt_q[r];
      if (src2_i == REG_IDX_W'(r)) c2 = cnt_q[r];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    else cnt_q <= cnt_d;
  // the write in WB commits at negedge, before ID samples, so it is discounted
  assign hazard1_o = src1_i != PC_IDX && c1 != CNT_W'(wb_we_i && wb_idx_i == src1_i);
  assign hazard2_o = use2_i && src2_i != PC_IDX && c2 != CNT_W'(wb_we_i && wb_idx_i == src2_i);
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_chk
    assert property (@(posedge clk) disable iff (rst) !(inc_v[g] && !dec_v[g] && cnt_q[g] == MAX));
    assert property (@(posedge clk) disable iff (rst) !(dec_v[g] && !inc_v[g] && cnt_q[g] == '0));
  end
endmodule

// File: rtl/wb_stage_scoreboard.sv
// wb_stage_scoreboard: MEM/WB register, write-back result select and in-flight write scoreboard
module wb_stage_scoreboard import arm_pkg::*; #(
  parameter int NUM_REGS = 15,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_valid,
  input  logic        mem_wb_en,
  input  logic        mem_r_en,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_data,
  input  logic [3:0]  mem_dest,
  input  logic        iss_valid,
  input  logic        iss_wb_en,
  input  logic [3:0]  iss_dest,
  input  logic [3:0]  q_src1,
  input  logic [3:0]  q_src2,
  input  logic        q_use2,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
  output logic        writeBackEn,
  output logic        hazard1,
  output logic        hazard2,
  output logic        pc_wr_err
);
  wb_bundle wb_q, wb_d;
  logic err_q, err_d, leave;
  always_comb begin
    wb_d = freeze ? wb_q : '{valid: mem_valid, wb_en: mem_wb_en, r_en: mem_r_en,
                            alu_res: mem_alu_res, data: mem_data, dest: mem_dest};
    leave = wb_q.valid && wb_q.wb_en && !freeze;
    err_d = err_q || (leave && wb_q.dest == PC_IDX);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_q <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q <= wb_d;
      err_q <= err_d;
    end
  assign Dest_wb = wb_q.dest;
  assign Result_WB = wb_q.r_en ? wb_q.data : wb_q.alu_res;
  assign writeBackEn = wb_q.valid && wb_q.wb_en && wb_q.dest != PC_IDX;
  assign pc_wr_err = err_q;
  wb_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (iss_valid && iss_wb_en && !freeze && iss_dest != PC_IDX),
    .inc_idx_i (iss_dest),
    .dec_i     (writeBackEn && !freeze),
    .dec_idx_i (wb_q.dest),
    .wb_we_i   (writeBackEn),
    .wb_idx_i  (wb_q.dest),
    .src1_i    (q_src1),
    .src2_i    (q_src2),
    .use2_i    (q_use2),
    .hazard1_o (hazard1),
    .hazard2_o (hazard2)
  );
endmodule

// File: tb/tb_wb_stage_scoreboard.sv
// tb_wb_stage_scoreboard: directed steps with a queue of expected write-backs
module tb_wb_stage_scoreboard;
  logic clk = 1'b0, rst = 1'b1, freeze = 1'b0;
  logic mem_valid = 1'b0, mem_wb_en = 1'b0, mem_r_en = 1'b0;
  logic [31:0] mem_alu_res = '0, mem_data = '0;
  logic [3:0] mem_dest = '0;
  logic iss_valid = 1'b0, iss_wb_en = 1'b0;
  logic [3:0] iss_dest = '0, q_src1 = '0, q_src2 = '0;
  logic q_use2 = 1'b0;
  logic [3:0] Dest_wb;
  logic [31:0] Result_WB;
  logic writeBackEn, hazard1, hazard2, pc_wr_err;
  typedef struct {
    logic        we;
    logic [3:0]  dest;
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  exp_t staged;
  bit staged_v = 0;
  bit exp_err = 0;
  int n_chk = 0, n_fail = 0;
  wb_stage_scoreboard dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .mem_valid(mem_valid), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
    .mem_alu_res(mem_alu_res), .mem_data(mem_data), .mem_dest(mem_dest),
    .iss_valid(iss_valid), .iss_wb_en(iss_wb_en), .iss_dest(iss_dest),
    .q_src1(q_src1), .q_src2(q_src2), .q_use2(q_use2),
    .Dest_wb(Dest_wb), .Result_WB(Result_WB), .writeBackEn(writeBackEn),
    .hazard1(hazard1), .hazard2(hazard2), .pc_wr_err(pc_wr_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] d);
    iss_valid = 1'b1;
    iss_wb_en = 1'b1;
    iss_dest = d;
  endtask
  task automatic mem(input logic [3:0] d, input logic r, input logic [31:0] a, input logic [31:0] dat);
    mem_valid = 1'b1;
    mem_wb_en = 1'b1;
    mem_r_en = r;
    mem_dest = d;
    mem_alu_res = a;
    mem_data = dat;
    staged = '{we: d != 4'd15, dest: d, res: r ? dat : a, err: d == 4'd15};
    staged_v = 1;
  endtask
  // checks one cycle at negedge, then advances to just after the next posedge
  task automatic nxt(input int h1, input int h2);
    @(negedge clk);
    if (h1 >= 0) chk("hazard1", 32'(hazard1), 32'(h1));
    if (h2 >= 0) chk("hazard2", 32'(hazard2), 32'(h2));
    chk("pc_wr_err", 32'(pc_wr_err), 32'(exp_err));
    if (sb_q.size() > 0) begin
      chk("writeBackEn", 32'(writeBackEn), 32'(sb_q[0].we));
      chk("Dest_wb", 32'(Dest_wb), 32'(sb_q[0].dest));
      chk("Result_WB", Result_WB, sb_q[0].res);
      if (!freeze) begin
        if (sb_q[0].err) exp_err = 1;
        sb_q.delete(0);
      end
    end else chk("wb_idle", 32'(writeBackEn), 32'd0);
    @(posedge clk);
    if (staged_v && !freeze) begin
      sb_q.push_back(staged);
      staged_v = 0;
    end
    #1;
    iss_valid = 1'b0;
    iss_wb_en = 1'b0;
    mem_valid = 1'b0;
    mem_wb_en = 1'b0;
    mem_r_en = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_Dest_wb", 32'(Dest_wb), 32'd0);
    chk("rst_Result_WB", Result_WB, 32'd0);
    chk("rst_writeBackEn", 32'(writeBackEn), 32'd0);
    chk("rst_pc_wr_err", 32'(pc_wr_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q_src1 = 4'(i);
      q_src2 = 4'(i);
      q_use2 = 1'b1;
      #1;
      chk("idle_hazard1", 32'(hazard1), 32'd0);
      chk("idle_hazard2", 32'(hazard2), 32'd0);
    end
    q_use2 = 1'b0;
    @(posedge clk);
    #1;
    // ALU write to R3
    q_src1 = 4'd3;
    issue(4'd3);
    nxt(0, 0);
    nxt(1, 0);
    nxt(1, 0);
    mem(4'd3, 1'b0, 32'h1234, 32'h0);
    nxt(1, 0);
    nxt(0, 0);
    nxt(0, 0);
    // load to R4 selects load data
    q_src1 = 4'd4;
    issue(4'd4);
    nxt(0, 0);
    nxt(1, 0);
    mem(4'd4, 1'b1, 32'h40, 32'hDEADBEEF);
    nxt(1, 0);
    nxt(0, 0);
    // two producers of R5 in flight
    q_src1 = 4'd5;
    issue(4'd5);
    nxt(0, 0);
    issue(4'd5);
    nxt(1, 0);
    q_src2 = 4'd5;
    mem(4'd5, 1'b0, 32'h55, 32'h0);
    nxt(1, 0);
    q_use2 = 1'b1;
    mem(4'd5, 1'b0, 32'h56, 32'h0);
    nxt(1, 1);
    nxt(0, 0);
    q_use2 = 1'b0;
    nxt(0, 0);
    // freeze with R7 in WB, then re-issue R7 on release
    q_src1 = 4'd7;
    issue(4'd7);
    nxt(0, 0);
    nxt(1, 0);
    mem(4'd7, 1'b0, 32'h77, 32'h0);
    nxt(1, 0);
    freeze = 1'b1;
    repeat (4) nxt(0, 0);
    freeze = 1'b0;
    issue(4'd7);
    nxt(0, 0);
    nxt(1, 0);
    mem(4'd7, 1'b0, 32'h78, 32'h0);
    nxt(1, 0);
    nxt(0, 0);
    // write to R15 is dropped and flags an error
    mem(4'd15, 1'b0, 32'hF, 32'h0);
    nxt(0, 0);
    nxt(0, 0);
    nxt(0, 0);
    nxt(0, 0);
    // asynchronous reset with R9 in WB
    q_src1 = 4'd9;
    issue(4'd9);
    nxt(0, 0);
    nxt(1, 0);
    mem(4'd9, 1'b0, 32'h99, 32'h0);
    nxt(1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_writeBackEn", 32'(writeBackEn), 32'd0);
    chk("arst_Dest_wb", 32'(Dest_wb), 32'd0);
    chk("arst_Result_WB", Result_WB, 32'd0);
    chk("arst_pc_wr_err", 32'(pc_wr_err), 32'd0);
    chk("arst_hazard1", 32'(hazard1), 32'd0);
    sb_q.delete();
    staged_v = 0;
    exp_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      q_src1 = 4'(i);
      q_src2 = 4'(15 - i);
      q_use2 = 1'b1;
      #1;
      chk("post_rst_hazard1", 32'(hazard1), 32'd0);
      chk("post_rst_hazard2", 32'(hazard2), 32'd0);
    end
    @(posedge clk);
    #1;
    nxt(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
